boot_sequencer: RTL and testbench
=================================

BOOT_SEQUENCER -- requirements
Module: boot_sequencer

Interface
REQ-001 Parameter DATA_W, default 32, width of instruction words, checksum and result.
REQ-002 Parameter ADDR_W, default 5, instruction-memory address width; depth WORDS = 2**ADDR_W.
REQ-003 Parameter RUN_CYCLES, default 35, number of clk cycles the CPU runs with reset released.
REQ-004 Parameter LOAD_TIMEOUT, default 255, maximum idle cycles between accepted words in LOAD.
REQ-005 clk  in  1  system clock; all state changes on the rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 start  in  1  request to begin a load-and-run sequence; sampled in IDLE and DONE.
REQ-008 abort  in  1  return to IDLE from LOAD or RUN.
REQ-009 load_valid  in  1  load_data holds a valid word.
REQ-010 load_data  in  DATA_W  instruction word to store.
REQ-011 load_ready  out  1  block accepts a word this cycle.
REQ-012 imem_we  out  1  instruction-memory write strobe.
REQ-013 imem_addr  out  ADDR_W  instruction-memory write address.
REQ-014 imem_wdata  out  DATA_W  instruction-memory write data.
REQ-015 cpu_reset  out  1  active-high reset driven to the multi-cycle CPU.
REQ-016 cpu_result  in  DATA_W  CPU result bus.
REQ-017 result  out  DATA_W  cpu_result captured at the end of RUN.
REQ-018 checksum  out  DATA_W  modulo-2**DATA_W sum of the words accepted in the current load.
REQ-019 busy  out  1  high in LOAD and RUN.
REQ-020 done  out  1  high in DONE.
REQ-021 error  out  1  sticky load-timeout flag.

Function
REQ-022 The FSM SHALL have exactly four states: IDLE, LOAD, RUN and DONE.
REQ-023 IDLE: cpu_reset=1, load_ready=0; start=1 SHALL go to LOAD, clearing word count, checksum, idle counter and error.
REQ-024 LOAD: load_ready=1, cpu_reset=1; a word is accepted on a cycle with load_valid&load_ready.
REQ-025 Accepted word: combinationally in the same cycle, imem_we=1, imem_addr=word count and imem_wdata=load_data; on that edge checksum += load_data (wrapping) and word count increments.
REQ-026 imem_we SHALL be 0 in every cycle without an accepted word.
REQ-027 Accepting word index WORDS-1 SHALL move to RUN on the next edge; no wrap of imem_addr within a load.
REQ-028 LOAD idle counter increments on each cycle without an accepted word and clears on an accepted word; reaching LOAD_TIMEOUT SHALL set error=1 and move to IDLE.
REQ-029 RUN: cpu_reset=0 for exactly RUN_CYCLES consecutive cycles; cycle counter starts at 0 on RUN entry.
REQ-030 On the edge ending RUN cycle RUN_CYCLES-1, result SHALL capture cpu_result and the FSM SHALL move to DONE.
REQ-031 DONE: cpu_reset=1, done=1; result and checksum held; start=1 SHALL go to LOAD (done falls, checksum and word count clear, result held).
REQ-032 abort=1 in LOAD or RUN SHALL go to IDLE on the next edge with cpu_reset=1 and result unchanged; abort is ignored in IDLE and DONE.
REQ-033 abort and start asserted together: abort wins in LOAD/RUN; start wins in IDLE/DONE.
REQ-034 abort asserted with an accepted word: the word is still written to memory; the FSM goes to IDLE.
REQ-035 Timeout and accepted word on the same cycle: the accepted word wins, the idle counter clears and error stays 0.
REQ-036 start SHALL be ignored in LOAD and RUN.

Reset
REQ-037 reset=0 SHALL asynchronously force IDLE with cpu_reset=1, load_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, busy=0, done=0, error=0, result=0 and checksum=0.
REQ-038 reset asserted during LOAD or RUN SHALL abort immediately; the sequence restarts only after reset=1 and a new start.
REQ-039 Counters SHALL clear to 0 on reset.

Verification
REQ-040 Default parameters; start; 32 words 0x00000001..0x00000020 with load_valid held high -> addresses 0..31 written in order, checksum=0x00000210, RUN entered on the cycle after the last write.
REQ-041 In RUN, drive cpu_result=0xDEADBEEF -> cpu_reset low for exactly 35 cycles, then done=1, result=0xDEADBEEF, cpu_reset=1.
REQ-042 Start, then 3 words, then load_valid=0 for 255 cycles -> error=1, IDLE, cpu_reset=1, no further imem_we.
REQ-043 Abort at RUN cycle 10 -> IDLE next edge, cpu_reset=1, result unchanged, done=0.
REQ-044 reset=0 mid-LOAD at word 7 -> all outputs at reset values immediately; a new start plus 32 words gives a checksum over the new words only.
REQ-045 In DONE, start and abort together -> LOAD entered, done=0, checksum=0.

Source files
------------

// File: rtl/boot_sequencer.sv
// Loads a program into instruction memory from a valid/ready word stream, then releases
// the CPU from reset for a fixed number of cycles and captures its result.
module boot_sequencer #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter int RUN_CYCLES   = 35,
  parameter int LOAD_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              cpu_reset,
  input  logic [DATA_W-1:0] cpu_result,
  output logic [DATA_W-1:0] result,
  output logic [DATA_W-1:0] checksum,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int RUN_W  = $clog2(RUN_CYCLES + 1);
  localparam int IDLE_W = $clog2(LOAD_TIMEOUT + 1);
  localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(RUN_CYCLES - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(LOAD_TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   word_cnt_q;
  logic [IDLE_W-1:0]   idle_cnt_q;
  logic [RUN_W-1:0]    run_cnt_q;
  logic [DATA_W-1:0]   checksum_q;
  logic [DATA_W-1:0]   result_q;
  logic                error_q;
  logic                accept;

  assign accept     = (state_q == S_LOAD) && load_valid;
  assign load_ready = (state_q == S_LOAD);
  assign imem_we    = accept;
  // Address and data are forced to zero off-write so reset and idle cycles show a clean bus.
  assign imem_addr  = accept ? word_cnt_q : '0;
  assign imem_wdata = accept ? load_data : '0;
  assign cpu_reset  = (state_q != S_RUN);
  assign busy       = (state_q == S_LOAD) || (state_q == S_RUN);
  assign done       = (state_q == S_DONE);
  assign error      = error_q;
  assign result     = result_q;
  assign checksum   = checksum_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      word_cnt_q <= '0;
      idle_cnt_q <= '0;
      run_cnt_q  <= '0;
      checksum_q <= '0;
      result_q   <= '0;
      error_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q    <= S_LOAD;
            word_cnt_q <= '0;
            idle_cnt_q <= '0;
            checksum_q <= '0;
            error_q    <= 1'b0;
          end
        end
        S_LOAD: begin
          if (accept) begin
            checksum_q <= checksum_q + load_data;
            word_cnt_q <= word_cnt_q + ADDR_W'(1);
            idle_cnt_q <= '0;
          end else begin
            idle_cnt_q <= idle_cnt_q + IDLE_W'(1);
          end
          // Priority: abort, then last word, then timeout (an accepted word never times out).
          if (abort) begin
            state_q <= S_IDLE;
          end else if (accept && (word_cnt_q == '1)) begin
            state_q   <= S_RUN;
            run_cnt_q <= '0;
          end else if (!accept && (idle_cnt_q == IDLE_LAST)) begin
            error_q <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        S_RUN: begin
          if (abort) begin
            state_q <= S_IDLE;
          end else if (run_cnt_q == RUN_LAST) begin
            result_q <= cpu_result;
            state_q  <= S_DONE;
          end else begin
            run_cnt_q <= run_cnt_q + RUN_W'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_boot_sequencer.sv
// Directed bench for boot_sequencer: a per-cycle vector table for the load handshake,
// then hand-written sequences for full load/run, timeout, abort and mid-load reset.
module tb_boot_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        load_valid = 1'b0;
  logic [31:0] load_data = '0;
  logic        load_ready;
  logic        imem_we;
  logic [4:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_reset;
  logic [31:0] cpu_result = '0;
  logic [31:0] result;
  logic [31:0] checksum;
  logic        busy;
  logic        done;
  logic        error;

  int n_cmp = 0;
  int n_err = 0;

  boot_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_reset(cpu_reset), .cpu_result(cpu_result), .result(result),
    .checksum(checksum), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        st, ab, lv;
    logic [31:0] ld;
    logic        e_rdy, e_we;
    logic [4:0]  e_addr;
    logic [31:0] e_wd;
    logic        e_busy, e_crst, sum_chk;
    logic [31:0] e_sum;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " cpu_reset"}, 32'(cpu_reset), 32'd1);
    check({tag, " load_ready"}, 32'(load_ready), 32'd0);
    check({tag, " imem_we"}, 32'(imem_we), 32'd0);
    check({tag, " imem_addr"}, 32'(imem_addr), 32'd0);
    check({tag, " imem_wdata"}, imem_wdata, 32'd0);
    check({tag, " busy"}, 32'(busy), 32'd0);
    check({tag, " done"}, 32'(done), 32'd0);
    check({tag, " error"}, 32'(error), 32'd0);
    check({tag, " result"}, result, 32'd0);
    check({tag, " checksum"}, checksum, 32'd0);
  endtask

  // From IDLE/DONE: start, stream 32 words base+i, then verify RUN entry in the next cycle.
  task automatic load32(input logic [31:0] base);
    logic [31:0] sum;
    sum = '0;
    @(negedge clk); start = 1'b1; abort = 1'b0; load_valid = 1'b0; #1;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk); start = 1'b0; load_valid = 1'b1; load_data = base + 32'(i); #1;
      check("load we", 32'(imem_we), 32'd1);
      check("load addr", 32'(imem_addr), 32'(i));
      check("load wdata", imem_wdata, base + 32'(i));
      sum = sum + base + 32'(i);
    end
    @(negedge clk); load_valid = 1'b0; #1;
    check("run entry busy", 32'(busy), 32'd1);
    check("run entry cpu_reset", 32'(cpu_reset), 32'd0);
    check("run entry load_ready", 32'(load_ready), 32'd0);
    check("load checksum", checksum, sum);
    $display("load32 base=%h checksum=%h", base, checksum);
  endtask

  // Called in RUN cycle 0; counts cycles with cpu_reset low, bounded.
  task automatic run_to_done();
    int cnt;
    cnt = 0;
    cpu_result = 32'h1000;
    while (cpu_reset == 1'b0 && cnt < 100) begin
      cnt++;
      @(negedge clk);
      cpu_result = (cnt == 34) ? 32'hDEADBEEF : 32'h1000 + 32'(cnt);
      #1;
    end
    check("run length", 32'(cnt), 32'd35);
    check("done flag", 32'(done), 32'd1);
    check("result capture", result, 32'hDEADBEEF);
    check("done cpu_reset", 32'(cpu_reset), 32'd1);
    $display("run finished after %0d cycles, result=%h", cnt, result);
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 5'd0, 32'h0,  1'b0, 1'b1, 1'b1, 32'h0};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 32'h55, 1'b0, 1'b0, 5'd0, 32'h0,  1'b0, 1'b1, 1'b1, 32'h0};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 32'h10, 1'b1, 1'b1, 5'd0, 32'h10, 1'b1, 1'b1, 1'b1, 32'h0};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 32'h99, 1'b1, 1'b0, 5'd0, 32'h0,  1'b1, 1'b1, 1'b1, 32'h10};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 32'h20, 1'b1, 1'b1, 5'd1, 32'h20, 1'b1, 1'b1, 1'b1, 32'h10};
    vecs[5] = '{1'b0, 1'b1, 1'b1, 32'h30, 1'b1, 1'b1, 5'd2, 32'h30, 1'b1, 1'b1, 1'b1, 32'h30};
    vecs[6] = '{1'b0, 1'b0, 1'b1, 32'h40, 1'b0, 1'b0, 5'd0, 32'h0,  1'b0, 1'b1, 1'b0, 32'h0};

    #2;
    check_reset_outputs("por");
    @(negedge clk); reset = 1'b1;

    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      start = vecs[i].st; abort = vecs[i].ab; load_valid = vecs[i].lv; load_data = vecs[i].ld;
      #1;
      check("vec load_ready", 32'(load_ready), 32'(vecs[i].e_rdy));
      check("vec imem_we", 32'(imem_we), 32'(vecs[i].e_we));
      check("vec imem_addr", 32'(imem_addr), 32'(vecs[i].e_addr));
      check("vec imem_wdata", imem_wdata, vecs[i].e_wd);
      check("vec busy", 32'(busy), 32'(vecs[i].e_busy));
      check("vec cpu_reset", 32'(cpu_reset), 32'(vecs[i].e_crst));
      if (vecs[i].sum_chk) check("vec checksum", checksum, vecs[i].e_sum);
      $display("vector %0d applied: we=%b addr=%0d busy=%b", i, imem_we, imem_addr, busy);
    end

    // Full load of 1..32 then run with result capture.
    load32(32'h1);
    run_to_done();

    // DONE: start and abort together restart the load.
    @(negedge clk); start = 1'b1; abort = 1'b1; #1;
    check("done hold result", result, 32'hDEADBEEF);
    @(negedge clk); start = 1'b0; abort = 1'b0; load_valid = 1'b0; #1;
    check("restart done", 32'(done), 32'd0);
    check("restart busy", 32'(load_ready), 32'd1);
    check("restart checksum", checksum, 32'd0);
    check("restart result held", result, 32'hDEADBEEF);

    // Three words, then 255 idle cycles -> timeout.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); load_valid = 1'b1; load_data = 32'hA0 + 32'(i); #1;
    end
    for (int i = 1; i <= 255; i++) begin
      @(negedge clk); load_valid = 1'b0; #1;
      check("timeout idle we", 32'(imem_we), 32'd0);
      if (i == 255) check("timeout last idle busy", 32'(busy), 32'd1);
    end
    @(negedge clk); #1;
    check("timeout error", 32'(error), 32'd1);
    check("timeout busy", 32'(busy), 32'd0);
    check("timeout cpu_reset", 32'(cpu_reset), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); load_valid = 1'b1; #1;
      check("post-timeout we", 32'(imem_we), 32'd0);
    end
    $display("timeout sequence done, error=%b", error);

    // Word accepted exactly on the would-be timeout cycle.
    @(negedge clk); start = 1'b1; load_valid = 1'b0; #1;
    @(negedge clk); start = 1'b0; #1;
    check("restart clears error", 32'(error), 32'd0);
    for (int i = 2; i <= 254; i++) begin
      @(negedge clk); #1;
    end
    @(negedge clk); load_valid = 1'b1; load_data = 32'h77; #1;
    check("edge accept we", 32'(imem_we), 32'd1);
    @(negedge clk); load_valid = 1'b0; #1;
    check("edge accept busy", 32'(busy), 32'd1);
    check("edge accept error", 32'(error), 32'd0);
    @(negedge clk); abort = 1'b1; #1;
    @(negedge clk); abort = 1'b0; #1;
    check("load abort busy", 32'(busy), 32'd0);
    $display("timeout-vs-accept sequence done");

    // Abort at RUN cycle 10, start ignored at cycle 5.
    load32(32'h200);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk); start = (k == 5); abort = (k == 10); #1;
    end
    check("run cycle10 cpu_reset", 32'(cpu_reset), 32'd0);
    @(negedge clk); abort = 1'b0; start = 1'b0; #1;
    check("run abort busy", 32'(busy), 32'd0);
    check("run abort cpu_reset", 32'(cpu_reset), 32'd1);
    check("run abort done", 32'(done), 32'd0);
    check("run abort result", result, 32'hDEADBEEF);
    $display("run abort sequence done");

    // Asynchronous reset in the middle of word 7.
    @(negedge clk); start = 1'b1; #1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk); start = 1'b0; load_valid = 1'b1; load_data = 32'hF00 + 32'(i); #1;
    end
    @(negedge clk); load_data = 32'hF07; #1;
    reset = 1'b0; #1;
    check_reset_outputs("midload");
    @(negedge clk); reset = 1'b1; load_valid = 1'b0; #1;
    check("post reset idle", 32'(busy), 32'd0);
    load32(32'h100);
    run_to_done();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
